// File: rtl/mem_port_arbiter.sv
// Two-port (fetch I / load-store D) arbiter in front of one fixed-latency memory.
// Define ARB_ROUND_ROBIN_EN for fair round robin; default is fixed priority D over I.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_owner_d;
  logic                r_owner_we;
  logic                r_i_rvalid;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                w_issue;
  logic                w_grant_d;
  logic                w_done;

  // Gating with reset keeps grants and strobes quiet while reset is held.
  assign w_issue = reset && (r_state == S_IDLE) && (i_req || d_req);
  assign w_done  = (r_state == S_WAIT) && (r_cnt == '0);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_d <= 1'b1;
    end else if (w_issue) begin
      r_last_d <= w_grant_d;
    end
  end

  always_comb begin
    w_grant_d = d_req;
    if (d_req && i_req) begin
      w_grant_d = ~r_last_d;
    end
  end
`else
  always_comb begin
    w_grant_d = d_req;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    busy    = (r_state == S_WAIT);
    if (w_issue) begin
      m_en = 1'b1;
      if (w_grant_d) begin
        d_gnt   = 1'b1;
        m_addr  = d_addr;
        m_we    = d_we;
        m_wdata = d_wdata;
        m_wstrb = d_wstrb;
      end else begin
        i_gnt   = 1'b1;
        m_addr  = i_addr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_owner_d  <= 1'b1;
      r_owner_we <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= w_done && !r_owner_d;
      r_d_rvalid <= w_done &&  r_owner_d;
      if (w_issue) begin
        r_cnt      <= CNT_W'(MEM_LAT - 1);
        r_owner_d  <= w_grant_d;
        r_owner_we <= w_grant_d && d_we;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done && !r_owner_d) begin
        r_i_rdata <= m_rdata;
      end
      // Stores only acknowledge; the last load data stays visible on d_rdata.
      if (w_done && r_owner_d && !r_owner_we) begin
        r_d_rdata <= m_rdata;
      end
    end
  end

  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;

endmodule
